// File: rtl/pc_8bit_stack.sv
// rtl/pc_8bit_stack.sv - program counter with a LIFO return-address stack
//
// Purpose:
//   Holds the instruction address for the next fetch stage. Each cycle it
//   holds, increments, loads a jump target, calls (push return address and
//   jump) or returns (pop). Priority: reset > ret > call > load > inc > hold.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   inA       in   [WIDTH] jump/call target from the upstream mux
//   load      in   jump: out <= inA
//   inc       in   advance: out <= out + 1 (wraps)
//   call      in   push out + 1, then out <= inA
//   ret       in   out <= popped return address
//   out       out  [WIDTH] current PC (registered)
//   depth     out  [DW] number of valid stack entries (registered)
//   overflow  out  sticky: call seen with the stack full
//   underflow out  sticky: ret seen with the stack empty

module pc_8bit_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int DW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] inA,
  input  logic             load,
  input  logic             inc,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] out,
  output logic [DW-1:0]    depth,
  output logic             overflow,
  output logic             underflow
);

  // Index width of the stack array; DEPTH is a power of two.
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_INC,
    CMD_LOAD,
    CMD_CALL,
    CMD_RET
  } cmd_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] stack_q [DEPTH];

  cmd_e             cmd;
  logic             stack_full;
  logic             stack_empty;
  logic             push_en;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    pop_idx;
  logic [DW-1:0]    depth_m1;
  logic [WIDTH-1:0] pc_plus1;

  assign stack_full  = (depth_q == DW'(DEPTH));
  assign stack_empty = (depth_q == '0);
  assign depth_m1    = depth_q - DW'(1);
  // depth only reaches DEPTH when full, and no push happens then, so the
  // low AW bits are a valid index whenever they are used.
  assign push_idx    = depth_q[AW-1:0];
  assign pop_idx     = depth_m1[AW-1:0];
  assign pc_plus1    = pc_q + WIDTH'(1);

  // Command decode in priority order; reset is handled in the register.
  always_comb begin
    cmd = CMD_HOLD;
    if (ret) begin
      cmd = CMD_RET;
    end else if (call) begin
      cmd = CMD_CALL;
    end else if (load) begin
      cmd = CMD_LOAD;
    end else if (inc) begin
      cmd = CMD_INC;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    unique case (cmd)
      CMD_INC:  pc_d = pc_plus1;
      CMD_LOAD: pc_d = inA;
      CMD_CALL: begin
        // The jump happens even when the push is refused.
        pc_d = inA;
        if (stack_full) begin
          ovf_d = 1'b1;
        end else begin
          push_en = 1'b1;
          depth_d = depth_q + DW'(1);
        end
      end
      CMD_RET: begin
        if (stack_empty) begin
          unf_d = 1'b1;
        end else begin
          pc_d    = stack_q[pop_idx];
          depth_d = depth_m1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents need no reset; depth alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset && push_en) begin
      stack_q[push_idx] <= pc_plus1;
    end
  end

  assign out       = pc_q;
  assign depth     = depth_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_pc_8bit_stack.sv
// tb/tb_pc_8bit_stack.sv - scoreboard bench for pc_8bit_stack

module tb_pc_8bit_stack;

  logic       clk;
  logic       reset;
  logic [7:0] inA;
  logic       load, inc, call, ret;
  logic [7:0] out;
  logic [2:0] depth;
  logic       overflow, underflow;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [7:0] out;
    logic [2:0] depth;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0] m_out;
  logic [2:0] m_depth;
  logic       m_ovf, m_unf;
  logic [7:0] m_stk [4];

  pc_8bit_stack #(.WIDTH(8), .DEPTH(4), .DW(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .inA      (inA),
    .load     (load),
    .inc      (inc),
    .call     (call),
    .ret      (ret),
    .out      (out),
    .depth    (depth),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference behaviour of one edge, applied to the bench's own state.
  task automatic model_step(input logic r, input logic rt, input logic cl,
                            input logic ld, input logic ic, input logic [7:0] a);
    if (r) begin
      m_out = 8'h00; m_depth = 3'd0; m_ovf = 1'b0; m_unf = 1'b0;
    end else if (rt) begin
      if (m_depth == 3'd0) m_unf = 1'b1;
      else begin
        m_depth = m_depth - 3'd1;
        m_out   = m_stk[m_depth[1:0]];
      end
    end else if (cl) begin
      if (m_depth == 3'd4) m_ovf = 1'b1;
      else begin
        m_stk[m_depth[1:0]] = m_out + 8'd1;
        m_depth = m_depth + 3'd1;
      end
      m_out = a;
    end else if (ld) begin
      m_out = a;
    end else if (ic) begin
      m_out = m_out + 8'd1;
    end
  endtask

  task automatic step(input logic r, input logic rt, input logic cl,
                      input logic ld, input logic ic, input logic [7:0] a);
    exp_t e;
    exp_t g;
    @(negedge clk);
    reset = r; ret = rt; call = cl; load = ld; inc = ic; inA = a;
    model_step(r, rt, cl, ld, ic, a);
    e.out = m_out; e.depth = m_depth; e.ovf = m_ovf; e.unf = m_unf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      g = exp_q.pop_front();
      check("out", {24'd0, out}, {24'd0, g.out});
      check("depth", {29'd0, depth}, {29'd0, g.depth});
      check("overflow", {31'd0, overflow}, {31'd0, g.ovf});
      check("underflow", {31'd0, underflow}, {31'd0, g.unf});
    end
  endtask

  // Shorthands: arguments are (reset, ret, call, load, inc, inA).
  task automatic do_reset(); step(1, 0, 0, 0, 0, 8'h00); endtask
  task automatic do_inc();   step(0, 0, 0, 0, 1, 8'h00); endtask
  task automatic do_load(input logic [7:0] a); step(0, 0, 0, 1, 0, a); endtask
  task automatic do_call(input logic [7:0] a); step(0, 0, 1, 0, 0, a); endtask
  task automatic do_ret();   step(0, 1, 0, 0, 0, 8'h00); endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_out = 8'h00; m_depth = 3'd0; m_ovf = 1'b0; m_unf = 1'b0;
    for (int i = 0; i < 4; i++) m_stk[i] = 8'h00;
    reset = 1'b1; inA = 8'h00; load = 0; inc = 0; call = 0; ret = 0;

    // Reset, load and increment with wrap.
    do_reset();
    check("rst_out", {24'd0, out}, 32'h00);
    check("rst_depth", {29'd0, depth}, 32'd0);
    do_load(8'hFE);
    check("ld_FE", {24'd0, out}, 32'hFE);
    do_inc();
    check("inc_FF", {24'd0, out}, 32'hFF);
    do_inc();
    check("inc_wrap", {24'd0, out}, 32'h00);
    check("wrap_noflag", {30'd0, overflow, underflow}, 32'd0);
    do_inc();
    check("inc_01", {24'd0, out}, 32'h01);

    // Priority: load beats inc; ret beats call and load.
    step(0, 0, 0, 1, 1, 8'h40);
    check("ld_over_inc", {24'd0, out}, 32'h40);
    step(0, 1, 1, 1, 0, 8'h99);
    check("ret_wins_out", {24'd0, out}, 32'h40);
    check("ret_wins_unf", {31'd0, underflow}, 32'd1);
    check("ret_wins_depth", {29'd0, depth}, 32'd0);
    do_inc();
    check("unf_sticky", {31'd0, underflow}, 32'd1);

    // Nested call and return.
    do_reset();
    do_load(8'h10);
    do_call(8'h80);
    check("call1_out", {24'd0, out}, 32'h80);
    check("call1_depth", {29'd0, depth}, 32'd1);
    do_call(8'hA0);
    check("call2_depth", {29'd0, depth}, 32'd2);
    do_ret();
    check("ret1_out", {24'd0, out}, 32'h81);
    do_ret();
    check("ret2_out", {24'd0, out}, 32'h11);
    check("ret2_depth", {29'd0, depth}, 32'd0);

    // Overflow: the fifth call still jumps but does not push.
    do_reset();
    for (int i = 0; i < 4; i++) do_call(8'h20 + 8'(i));
    check("full_depth", {29'd0, depth}, 32'd4);
    do_call(8'h55);
    check("ovf_out", {24'd0, out}, 32'h55);
    check("ovf_depth", {29'd0, depth}, 32'd4);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    do_ret();
    check("ovf_ret1", {24'd0, out}, 32'h23);
    do_ret();
    do_ret();
    do_ret();
    check("ovf_ret4", {24'd0, out}, 32'h01);
    check("ovf_empty", {29'd0, depth}, 32'd0);

    // Pushing from FF stores 00.
    do_reset();
    do_load(8'hFF);
    do_call(8'h30);
    check("wcall_out", {24'd0, out}, 32'h30);
    do_ret();
    check("wret_out", {24'd0, out}, 32'h00);

    // Reset overrides a concurrent call mid-sequence.
    do_reset();
    for (int i = 0; i < 5; i++) do_call(8'h60 + 8'(i));
    do_ret();
    check("pre_depth3", {29'd0, depth}, 32'd3);
    check("pre_ovf", {31'd0, overflow}, 32'd1);
    step(1, 0, 1, 0, 0, 8'h77);
    check("rstcall_out", {24'd0, out}, 32'h00);
    check("rstcall_depth", {29'd0, depth}, 32'd0);
    check("rstcall_flags", {30'd0, overflow, underflow}, 32'd0);
    do_ret();
    check("post_unf", {31'd0, underflow}, 32'd1);

    // Random command mix against the model.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] sel;
      sel = 4'($urandom_range(0, 15));
      step(sel == 4'd0 && ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
